// File: rtl/control_riesgos_if.sv
// Signal bundle between the hazard-detection side of the pipeline and the
// hazard scheduler: register operands, memory handshake, branch, enables.
interface control_riesgos_if;
    logic [3:0]  Ra_ID;
    logic        RE_A_ID;
    logic [3:0]  Rb_ID;
    logic        RE_B_ID;
    logic [3:0]  Rd_EX;
    logic        mem_RE_EX;
    logic        mem_req;
    logic        mem_ack;
    logic        branch_taken_EX;
    logic        PC_EN;
    logic        IF_ID_EN;
    logic        ID_EX_EN;
    logic        NOP_Mux;
    logic        IF_ID_flush;
    logic        mem_error;
    logic [15:0] stall_cnt;

    modport master (
        output Ra_ID, RE_A_ID, Rb_ID, RE_B_ID, Rd_EX, mem_RE_EX,
               mem_req, mem_ack, branch_taken_EX,
        input  PC_EN, IF_ID_EN, ID_EX_EN, NOP_Mux, IF_ID_flush,
               mem_error, stall_cnt
    );

    modport slave (
        input  Ra_ID, RE_A_ID, Rb_ID, RE_B_ID, Rd_EX, mem_RE_EX,
               mem_req, mem_ack, branch_taken_EX,
        output PC_EN, IF_ID_EN, ID_EX_EN, NOP_Mux, IF_ID_flush,
               mem_error, stall_cnt
    );
endinterface

// File: rtl/control_riesgos.sv
// Pipeline hazard scheduler: load-use stalls, memory wait states with timeout
// and branch flushes. Define STALL_COUNTER_EN to build the stall statistics counter.
module control_riesgos #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    control_riesgos_if.slave bus
);

    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] LOAD_STALL = 2'd1;
    localparam logic [1:0] MEM_WAIT   = 2'd2;
    localparam logic [1:0] ERROR      = 2'd3;

    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);

    logic [1:0] state_q, state_d;
    logic [2:0] stall_left_q, stall_left_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_error_q, mem_error_d;

    logic hz, mw;
    logic pc_en, if_id_en, id_ex_en, nop_mux, if_id_flush;

    assign hz = bus.mem_RE_EX &&
                ((bus.RE_A_ID && (bus.Ra_ID == bus.Rd_EX)) ||
                 (bus.RE_B_ID && (bus.Rb_ID == bus.Rd_EX)));
    assign mw = bus.mem_req && !bus.mem_ack;

    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        wait_cnt_d   = wait_cnt_q;
        mem_error_d  = mem_error_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        nop_mux      = 1'b0;
        if_id_flush  = 1'b0;

        case (state_q)
            RUN, LOAD_STALL: begin
                if (mw) begin
                    // The request cycle is the first unacknowledged cycle.
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    stall_left_d = 3'd0;
                    wait_cnt_d   = 8'd1;
                    if (TIMEOUT == 8'd1) begin
                        state_d     = ERROR;
                        mem_error_d = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end else if (state_q == LOAD_STALL) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    nop_mux      = 1'b1;
                    stall_left_d = stall_left_q - 3'd1;
                    if (stall_left_q == 3'd1)
                        state_d = RUN;
                end else if (bus.branch_taken_EX) begin
                    if_id_flush = 1'b1;
                    nop_mux     = 1'b1;
                end else if (hz) begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    nop_mux  = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        stall_left_d = STALL_INIT;
                        state_d      = LOAD_STALL;
                    end
                end
            end
            MEM_WAIT: begin
                if (!bus.mem_ack) begin
                    pc_en      = 1'b0;
                    if_id_en   = 1'b0;
                    id_ex_en   = 1'b0;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == TIMEOUT) begin
                        state_d     = ERROR;
                        mem_error_d = 1'b1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                id_ex_en = 1'b0;
            end
        endcase

        // Reset values are driven straight from rst_n, independent of the clock.
        if (!rst_n) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            nop_mux     = 1'b1;
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            stall_left_q <= 3'd0;
            wait_cnt_q   <= 8'd0;
            mem_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_error_q  <= mem_error_d;
        end
    end

    assign bus.PC_EN       = pc_en;
    assign bus.IF_ID_EN    = if_id_en;
    assign bus.ID_EX_EN    = id_ex_en;
    assign bus.NOP_Mux     = nop_mux;
    assign bus.IF_ID_flush = if_id_flush;
    assign bus.mem_error   = mem_error_q;

`ifdef STALL_COUNTER_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= 16'd0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_control_riesgos.sv
// Directed bench for control_riesgos: a cycle-by-cycle vector table plus
// hand-written reset, memory-wait, timeout and mid-stall reset sequences.
module tb_control_riesgos;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0] ra, rb, rd;
    logic       rea, reb, mre, req, ack, br;

    control_riesgos_if bus_a ();
    control_riesgos_if bus_b ();

    assign bus_a.Ra_ID = ra;  assign bus_a.RE_A_ID = rea;
    assign bus_a.Rb_ID = rb;  assign bus_a.RE_B_ID = reb;
    assign bus_a.Rd_EX = rd;  assign bus_a.mem_RE_EX = mre;
    assign bus_a.mem_req = req; assign bus_a.mem_ack = ack;
    assign bus_a.branch_taken_EX = br;
    assign bus_b.Ra_ID = ra;  assign bus_b.RE_A_ID = rea;
    assign bus_b.Rb_ID = rb;  assign bus_b.RE_B_ID = reb;
    assign bus_b.Rd_EX = rd;  assign bus_b.mem_RE_EX = mre;
    assign bus_b.mem_req = req; assign bus_b.mem_ack = ack;
    assign bus_b.branch_taken_EX = br;

    control_riesgos #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    control_riesgos #(.LOAD_STALL_CYCLES(5), .MEM_TIMEOUT(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic [4:0] out_a, out_b;
    assign out_a = {bus_a.PC_EN, bus_a.IF_ID_EN, bus_a.ID_EX_EN, bus_a.NOP_Mux, bus_a.IF_ID_flush};
    assign out_b = {bus_b.PC_EN, bus_b.IF_ID_EN, bus_b.ID_EX_EN, bus_b.NOP_Mux, bus_b.IF_ID_flush};

    // {PC_EN, IF_ID_EN, ID_EX_EN, NOP_Mux, IF_ID_flush}
    localparam logic [4:0] D  = 5'b11100;
    localparam logic [4:0] S  = 5'b00110;
    localparam logic [4:0] F  = 5'b00000;
    localparam logic [4:0] B  = 5'b11111;
    localparam logic [4:0] RS = 5'b00011;

    typedef struct packed {
        logic [3:0] ra;
        logic       rea;
        logic [3:0] rb;
        logic       reb;
        logic [3:0] rd;
        logic       mre, req, ack, br;
        logic [4:0] exp;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [0:NV-1];

    int n_cmp = 0;
    int n_err = 0;

    function automatic vec_t mk(logic [3:0] a, logic ea, logic [3:0] b, logic eb,
                                logic [3:0] d, logic m, logic q, logic k, logic t,
                                logic [4:0] e);
        vec_t v;
        v = '{ra:a, rea:ea, rb:b, reb:eb, rd:d, mre:m, req:q, ack:k, br:t, exp:e};
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        ra = v.ra; rea = v.rea; rb = v.rb; reb = v.reb; rd = v.rd;
        mre = v.mre; req = v.req; ack = v.ack; br = v.br;
    endtask

    task automatic idle();
        ra = 4'd1; rea = 1'b0; rb = 4'd2; reb = 1'b0; rd = 4'd7;
        mre = 1'b0; req = 1'b0; ack = 1'b0; br = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] s0, exp_cnt;

    initial begin
        vecs[0]  = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, D);
        vecs[1]  = mk(4'd5, 1, 4'd0, 0, 4'd5, 1, 0, 0, 0, S);
        vecs[2]  = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, S);
        vecs[3]  = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, S);
        vecs[4]  = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, D);
        vecs[5]  = mk(4'd5, 0, 4'd0, 0, 4'd5, 1, 0, 0, 0, D);
        vecs[6]  = mk(4'd5, 1, 4'd0, 0, 4'd5, 0, 0, 0, 0, D);
        vecs[7]  = mk(4'd5, 1, 4'd3, 1, 4'd3, 1, 0, 0, 0, S);
        vecs[8]  = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, S);
        vecs[9]  = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, S);
        vecs[10] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, D);
        vecs[11] = mk(4'd0, 1, 4'd0, 0, 4'd0, 1, 0, 0, 0, S);
        vecs[12] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, S);
        vecs[13] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, S);
        vecs[14] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, D);
        vecs[15] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 1, B);
        vecs[16] = mk(4'd5, 1, 4'd0, 0, 4'd5, 1, 0, 0, 1, B);
        vecs[17] = mk(4'd5, 1, 4'd0, 0, 4'd5, 1, 0, 0, 0, S);
        vecs[18] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, S);
        vecs[19] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, S);
        vecs[20] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, D);
        vecs[21] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 1, 1, 0, D);
        vecs[22] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 1, 0, 1, F);
        vecs[23] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 1, 1, 1, D);
        vecs[24] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 1, B);
        vecs[25] = mk(4'd4, 1, 4'd9, 0, 4'd9, 1, 0, 0, 0, D);
        vecs[26] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, D);
        vecs[27] = mk(4'd5, 1, 4'd0, 0, 4'd5, 1, 0, 0, 0, S);
        vecs[28] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 1, 0, 0, F);
        vecs[29] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 1, 1, 0, D);
        vecs[30] = mk(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, D);

        idle();
        rst_n = 1'b0;
        #12;
        chk("reset_out_a", 16'(out_a), 16'(RS));
        chk("reset_out_b", 16'(out_b), 16'(RS));
        chk("reset_err_a", 16'(bus_a.mem_error), 16'd0);
        chk("reset_cnt_a", bus_a.stall_cnt, 16'd0);
        next();
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            $display("row %0d out=%b exp=%b", i, out_a, vecs[i].exp);
            chk($sformatf("vec_row%0d", i), 16'(out_a), 16'(vecs[i].exp));
            next();
        end

        // Four unacknowledged memory cycles, release in the ack cycle.
        idle();
        req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) s0 = bus_a.stall_cnt;
            $display("memwait cycle %0d out=%b", c, out_a);
            chk($sformatf("memwait_freeze%0d", c), 16'(out_a), 16'(F));
            next();
        end
        ack = 1'b1;
        @(negedge clk);
        chk("memwait_release", 16'(out_a), 16'(D));
        next();
        idle();
        @(negedge clk);
`ifdef STALL_COUNTER_EN
        exp_cnt = s0 + 16'd4;
`else
        exp_cnt = 16'd0;
`endif
        $display("memwait stall_cnt=%0d", bus_a.stall_cnt);
        chk("memwait_stall_cnt", bus_a.stall_cnt, exp_cnt);
        chk("memwait_after", 16'(out_a), 16'(D));
        next();

        // Timeout: error must rise only on the edge ending the 8th cycle.
        req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            $display("timeout cycle %0d out=%b err=%b", c, out_a, bus_a.mem_error);
            chk($sformatf("timeout_freeze%0d", c), 16'(out_a), 16'(F));
            chk($sformatf("timeout_noerr%0d", c), 16'(bus_a.mem_error), 16'd0);
            next();
        end
        idle();
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin req = 1'b1; ack = 1'b1; end
            @(negedge clk);
            $display("error cycle %0d out=%b err=%b", c, out_a, bus_a.mem_error);
            chk($sformatf("error_sticky%0d", c), 16'(bus_a.mem_error), 16'd1);
            chk($sformatf("error_freeze%0d", c), 16'(out_a), 16'(F));
            next();
        end
        idle();
        rst_n = 1'b0;
        #1;
        chk("err_reset_out", 16'(out_a), 16'(RS));
        chk("err_reset_flag", 16'(bus_a.mem_error), 16'd0);
        next();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_out_a", 16'(out_a), 16'(D));
        chk("post_reset_cnt_a", bus_a.stall_cnt, 16'd0);
        chk("post_reset_out_b", 16'(out_b), 16'(D));
        next();

        // Five-cycle stall on the second instance.
        ra = 4'd5; rea = 1'b1; rd = 4'd5; mre = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            $display("stall5 cycle %0d out=%b", c, out_b);
            chk($sformatf("stall5_c%0d", c), 16'(out_b), (c < 5) ? 16'(S) : 16'(D));
            next();
            idle();
        end

        // Reset dropped in the 2nd cycle of a 5-cycle stall.
        ra = 4'd5; rea = 1'b1; rd = 4'd5; mre = 1'b1;
        @(negedge clk);
        chk("midstall_c1", 16'(out_b), 16'(S));
        next();
        idle();
        #1;
        chk("midstall_c2", 16'(out_b), 16'(S));
        rst_n = 1'b0;
        #1;
        $display("midstall reset out=%b", out_b);
        chk("midstall_reset_out", 16'(out_b), 16'(RS));
        next();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            $display("after reset cycle %0d out=%b", c, out_b);
            chk($sformatf("midstall_after%0d", c), 16'(out_b), 16'(D));
            next();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
